// File: rtl/regfile_pkg.sv
// Shared types, default sizes and the write-port priority helper for the multi-port register file.
package regfile_pkg;

    typedef enum logic {RF_CLEAR, RF_READY} rf_state_e;

    localparam int RF_XLEN  = 32;
    localparam int RF_DEPTH = 32;
    // Widest write-port vector the priority helper accepts; NUM_WR must not exceed it.
    localparam int PRIO_MAX = 16;

    // Highest-numbered set bit of a write-port match vector, 0 when none is set.
    function automatic int prio_match(input logic [PRIO_MAX-1:0] match);
        int sel;
        sel = 0;
        for (int i = 0; i < PRIO_MAX; i++) begin
            if (match[i]) sel = i;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: sweeps every entry to zero after reset or on clear_req, then holds READY.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH = RF_DEPTH,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    rf_state_e     state, state_nx;
    logic [AW-1:0] idx, idx_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RF_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // A clear_req seen during the sweep is ignored: the CLEAR arm never looks at it.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            RF_CLEAR: begin
                if (idx == AW'(DEPTH - 1)) begin
                    state_nx = RF_READY;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + AW'(1);
                end
            end
            RF_READY: begin
                if (clear_req) begin
                    state_nx = RF_CLEAR;
                    idx_nx   = '0;
                end
            end
            default: begin
                state_nx = RF_CLEAR;
                idx_nx   = '0;
            end
        endcase
    end

    assign ready    = (state == RF_READY);
    assign clr_we   = (state == RF_CLEAR);
    assign clr_addr = idx;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with hardware clear sweep and optional x0.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear_req,
    output logic                   ready,
    input  logic [NUM_WR-1:0]      we,
    input  logic [NUM_WR*AW-1:0]   waddr,
    input  logic [NUM_WR*XLEN-1:0] wdata,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];
    logic [AW-1:0]   waddr_a [NUM_WR];
    logic [XLEN-1:0] wdata_a [NUM_WR];
    logic [AW-1:0]   raddr_a [NUM_RD];
    logic [NUM_WR-1:0] wr_win;
    logic            clr_we;
    logic [AW-1:0]   clr_addr;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    regfile_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .clear_req(clear_req),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    always_comb begin
        for (int p = 0; p < NUM_WR; p++) begin
            waddr_a[p] = waddr[p*AW +: AW];
            wdata_a[p] = wdata[p*XLEN +: XLEN];
        end
        for (int p = 0; p < NUM_RD; p++) begin
            raddr_a[p] = raddr[p*AW +: AW];
        end
    end

    // A port writes only if it is the highest-numbered enabled port targeting its address.
    always_comb begin
        logic [PRIO_MAX-1:0] m;
        m      = '0;
        wr_win = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            m = '0;
            for (int q = 0; q < NUM_WR; q++) begin
                m[q] = we[q] && (waddr_a[q] == waddr_a[p]);
            end
            wr_win[p] = ready && we[p] && !is_zero(waddr_a[p]) && (prio_match(m) == p);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_win[p]) mem[waddr_a[p]] <= wdata_a[p];
            end
        end
    end

`ifdef REGFILE_MP_BYPASS_EN
    localparam int WPW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

    always_comb begin
        logic [PRIO_MAX-1:0] m;
        m     = '0;
        rdata = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            m = '0;
            for (int q = 0; q < NUM_WR; q++) begin
                m[q] = we[q] && (waddr_a[q] == raddr_a[p]);
            end
            if (ready && !is_zero(raddr_a[p])) begin
                if (|m) rdata[p*XLEN +: XLEN] = wdata_a[WPW'(prio_match(m))];
                else    rdata[p*XLEN +: XLEN] = mem[raddr_a[p]];
            end
        end
    end
`else
    always_comb begin
        rdata = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ready && !is_zero(raddr_a[p])) rdata[p*XLEN +: XLEN] = mem[raddr_a[p]];
        end
    end
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters, ZERO_REG=1).
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req;
    logic        ready;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [31:0] rd0, rd1;

    int checks = 0;
    int errors = 0;

    assign rd0 = rdata[31:0];
    assign rd1 = rdata[63:32];

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .rst      (rst),
        .clear_req(clear_req),
        .ready    (ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                            input logic e1, input logic [4:0] a1, input logic [31:0] d1);
        we    = {e1, e0};
        waddr = {a1, a0};
        wdata = {d1, d0};
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 | 32'(i);
    endfunction

    // Counts 32 edges from the first sweep edge; ready must stay low through edge 31.
    task automatic sweep_check(input string tag);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 16) chk({tag, "_rd_mid"}, rd0, 32'h0);
            if (k == 31) chk({tag, "_ready_31"}, {31'b0, ready}, 32'h0);
            if (k == 32) chk({tag, "_ready_32"}, {31'b0, ready}, 32'h1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks %0d", checks);
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        clear_req = 1'b0;
        drive_wr(0, 0, 0, 0, 0, 0);
        raddr = '0;
        tick();
        tick();
        set_rd(5, 31);
        chk("rst_ready", {31'b0, ready}, 32'h0);
        chk("rst_rd0", rd0, 32'h0);
        chk("rst_rd1", rd1, 32'h0);

        // Power-on sweep
        rst = 1'b0;
        sweep_check("init");
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(31 - a));
            chk($sformatf("init_zero_%0d", a), rd0, 32'h0);
        end
        chk("init_zero_rd1", rd1, 32'h0);

        // Single write, same-cycle and next-cycle read
        drive_wr(1, 5, 32'hDEAD_BEEF, 0, 0, 0);
        set_rd(5, 5);
        chk("byp5", rd0, BYP ? 32'hDEAD_BEEF : 32'h0);
        tick();
        drive_wr(0, 0, 0, 0, 0, 0);
        set_rd(5, 5);
        chk("wr5_p0", rd0, 32'hDEAD_BEEF);
        chk("wr5_p1", rd1, 32'hDEAD_BEEF);

        // Conflict: port 1 wins
        drive_wr(1, 7, 32'h1111_1111, 1, 7, 32'h2222_2222);
        set_rd(7, 5);
        chk("byp7", rd0, BYP ? 32'h2222_2222 : 32'h0);
        chk("byp7_other", rd1, 32'hDEAD_BEEF);
        tick();
        drive_wr(0, 0, 0, 0, 0, 0);
        set_rd(7, 7);
        chk("conflict7", rd0, 32'h2222_2222);

        // Distinct addresses both land
        drive_wr(1, 8, 32'hAAAA_0008, 1, 9, 32'hBBBB_0009);
        tick();
        drive_wr(0, 0, 0, 0, 0, 0);
        set_rd(8, 9);
        chk("dual8", rd0, 32'hAAAA_0008);
        chk("dual9", rd1, 32'hBBBB_0009);

        // Zero register
        drive_wr(1, 0, 32'hFFFF_FFFF, 0, 0, 0);
        set_rd(0, 0);
        chk("x0_same", rd0, 32'h0);
        tick();
        drive_wr(0, 0, 0, 1, 0, 32'hFFFF_FFFF);
        set_rd(0, 0);
        chk("x0_after", rd0, 32'h0);
        chk("x0_same_p1", rd1, 32'h0);
        tick();
        drive_wr(0, 0, 0, 0, 0, 0);
        set_rd(0, 0);
        chk("x0_after_p1", rd1, 32'h0);

        // Fill 1..31, then clear via clear_req
        for (int i = 1; i < 32; i += 2) begin
            drive_wr(1, 5'(i), pat(i), (i + 1 < 32), 5'(i + 1), pat(i + 1));
            tick();
        end
        drive_wr(0, 0, 0, 0, 0, 0);
        set_rd(1, 31);
        chk("fill1", rd0, pat(1));
        chk("fill31", rd1, pat(31));
        set_rd(16, 2);
        chk("fill16", rd0, pat(16));
        chk("fill2", rd1, pat(2));

        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        set_rd(31, 1);
        chk("clr_ready_lo", {31'b0, ready}, 32'h0);
        chk("clr_rd_lo", rd0, 32'h0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (k == 5)  clear_req = 1'b1;
            if (k == 6)  clear_req = 1'b0;
            if (k == 10) drive_wr(1, 2, 32'hCAFE_F00D, 1, 3, 32'hCAFE_0003);
            if (k == 11) drive_wr(0, 0, 0, 0, 0, 0);
            if (k == 31) chk("clr_ready_31", {31'b0, ready}, 32'h0);
            if (k == 32) chk("clr_ready_32", {31'b0, ready}, 32'h1);
        end
        for (int a = 0; a < 32; a++) begin
            set_rd(5'(a), 5'(a));
            chk($sformatf("clr_zero_%0d", a), rd0, 32'h0);
        end

        // Reset mid-sweep restarts from index 0
        drive_wr(1, 4, 32'h4444_4444, 0, 0, 0);
        tick();
        drive_wr(0, 0, 0, 0, 0, 0);
        set_rd(4, 4);
        chk("pre_rst4", rd0, 32'h4444_4444);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", {31'b0, ready}, 32'h0);
        chk("mid_rst_rd", rd0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        sweep_check("rst_mid");
        set_rd(4, 31);
        chk("post_rst4", rd0, 32'h0);
        chk("post_rst31", rd1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
